// File: rtl/tone_synth_if.sv
// Note-select / DAC-FIFO handshake bundle for tone_synth.
// The master side drives the note controls and FIFO-ready flag.
// The slave side is the synthesiser, which returns the write strobe and sample.
interface tone_synth_if #(
    parameter int NUM_NOTES = 4,
    parameter int HP_W      = 8,
    parameter int OUT_W     = 32
) ();
    logic [NUM_NOTES-1:0]      note_en;
    logic [NUM_NOTES*HP_W-1:0] note_half_period;
    logic                      audio_out_allowed;
    logic                      write_audio_out;
    logic [OUT_W-1:0]          sample_out;
    logic                      active;

    modport master (
        output note_en, note_half_period, audio_out_allowed,
        input  write_audio_out, sample_out, active
    );

    modport slave (
        input  note_en, note_half_period, audio_out_allowed,
        output write_audio_out, sample_out, active
    );
endinterface

// File: rtl/tone_synth.sv
// Polyphonic square-wave tone generator with per-voice linear attack/release.
// It produces one mixed sample per FIFO write.
// Voice state (counter, phase, gain) only advances on an accepted write, so back-pressure
// freezes everything.
// The interface instance must be built with the same NUM_NOTES/HP_W/OUT_W as this module.
// OUT_W must be at least AMP_W+ENV_W+clog2(NUM_NOTES).
module tone_synth #(
    parameter int NUM_NOTES = 4,
    parameter int HP_W      = 8,
    parameter int AMP_W     = 16,
    parameter int ENV_W     = 8,
    parameter int ENV_STEP  = 1,
    parameter int OUT_W     = 32
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    tone_synth_if.slave bus
);
    localparam int PROD_W = AMP_W + ENV_W;
    localparam int SUM_W  = PROD_W + $clog2(NUM_NOTES);
    localparam int SHIFT  = OUT_W - SUM_W;

    localparam logic [ENV_W-1:0]        GMAX    = '1;
    localparam logic [ENV_W-1:0]        STEP    = ENV_W'(ENV_STEP);
    localparam logic signed [AMP_W-1:0] AMP_POS = AMP_W'((2 ** (AMP_W - 1)) - 1);
    localparam logic signed [AMP_W-1:0] AMP_NEG = -AMP_POS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MIX   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                   r_state;
    logic signed [OUT_W-1:0]  r_sample;

    logic [NUM_NOTES-1:0]     w_key;
    logic [NUM_NOTES-1:0]     w_gain_zero_next;
    logic signed [PROD_W-1:0] w_prod [NUM_NOTES];
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [OUT_W-1:0]  w_sample;
    logic                     w_write;
    logic                     w_go_idle;

    // Strobe straight from the state register.
    // It is gated by reset so that nothing is written in a reset cycle.
    assign w_write = (r_state == S_WRITE) & bus.audio_out_allowed & ~reset;

    // After this write's update, return to IDLE only when every envelope has
    // died out and nothing is keyed.
    assign w_go_idle = (&w_gain_zero_next) & ~(|w_key);

    generate
        for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_voice
            logic [HP_W-1:0]  r_cnt;
            logic             r_ph;
            logic [ENV_W-1:0] r_gain;
            logic [HP_W-1:0]  w_hp;
            logic             w_run;
            logic [ENV_W-1:0] w_gain_next;
            logic [HP_W-1:0]  w_cnt_next;
            logic             w_ph_next;

            assign w_hp      = bus.note_half_period[gi*HP_W +: HP_W];
            assign w_key[gi] = bus.note_en[gi] & (w_hp != '0);
            // A released voice keeps running until its envelope reaches zero.
            assign w_run     = w_key[gi] | (r_gain != '0);

            // Saturating envelope step: ramp up while keyed, down otherwise.
            always_comb begin
                if (w_key[gi]) begin
                    w_gain_next = (r_gain > (GMAX - STEP)) ? GMAX : (r_gain + STEP);
                end else begin
                    w_gain_next = (r_gain < STEP) ? '0 : (r_gain - STEP);
                end
            end

            // Oscillator: the >= compare copes with a half-period shrinking mid-count.
            // hp = 0 during release holds the phase.
            always_comb begin
                w_cnt_next = r_cnt;
                w_ph_next  = r_ph;
                if (!w_run) begin
                    w_cnt_next = '0;
                    w_ph_next  = 1'b0;
                end else if (w_hp != '0) begin
                    if (r_cnt >= (w_hp - HP_W'(1))) begin
                        w_cnt_next = '0;
                        w_ph_next  = ~r_ph;
                    end else begin
                        w_cnt_next = r_cnt + HP_W'(1);
                    end
                end
            end

            assign w_gain_zero_next[gi] = (w_gain_next == '0);
            assign w_prod[gi] = PROD_W'(r_ph ? AMP_NEG : AMP_POS)
                              * PROD_W'($signed({1'b0, r_gain}));

            // Voice state advances only on an accepted write.
            always_ff @(posedge CLOCK_50) begin
                if (reset) begin
                    r_cnt  <= '0;
                    r_ph   <= 1'b0;
                    r_gain <= '0;
                end else if (w_write) begin
                    r_cnt  <= w_cnt_next;
                    r_ph   <= w_ph_next;
                    r_gain <= w_gain_next;
                end
            end
        end
    endgenerate

    // Mix all voices at full precision, then left-justify into the output word.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            w_sum = w_sum + SUM_W'(w_prod[i]);
        end
    end

    assign w_sample = OUT_W'(w_sum) << SHIFT;

    // Sequencer: IDLE -> MIX (latch sample) -> WRITE (wait for FIFO room) -> MIX/IDLE.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sample <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_key) begin
                        r_state <= S_MIX;
                    end
                end
                S_MIX: begin
                    r_sample <= w_sample;
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    if (w_write) begin
                        r_state <= w_go_idle ? S_IDLE : S_MIX;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.write_audio_out = w_write;
    assign bus.sample_out      = r_sample;
    assign bus.active          = (r_state != S_IDLE);
endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth.
// A behavioural voice model predicts each sample when a note step is driven and
// queues it.
// A monitor pops and compares on every observed write strobe.
module tb_tone_synth;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tone_synth_if #(.NUM_NOTES(4), .HP_W(8), .OUT_W(32)) snd ();

    tone_synth dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (snd)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    int          wr_count = 0;
    logic [31:0] exp_q [$];
    logic [31:0] last_sample = '0;

    // Reference voice model.
    int m_cnt  [4];
    int m_ph   [4];
    int m_gain [4];
    bit m_idle;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_sample();
        longint s = 0;
        for (int i = 0; i < 4; i++) begin
            s += (m_ph[i] != 0 ? -32767 : 32767) * m_gain[i];
        end
        return 32'(s * 64);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = 0;
            m_ph[i]   = 0;
            m_gain[i] = 0;
        end
        m_idle = 1'b1;
    endtask

    task automatic model_update(input logic [3:0] en, input logic [31:0] hp);
        bit any_key  = 1'b0;
        bit all_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int h;
            bit key;
            bit run;
            h   = int'(hp[i*8 +: 8]);
            key = en[i] && (h != 0);
            run = key || (m_gain[i] != 0);
            if (key) m_gain[i] = (m_gain[i] + 1 > 255) ? 255 : m_gain[i] + 1;
            else     m_gain[i] = (m_gain[i] - 1 < 0)   ? 0   : m_gain[i] - 1;
            if (run) begin
                if (h != 0) begin
                    if (m_cnt[i] >= h - 1) begin
                        m_cnt[i] = 0;
                        m_ph[i]  = 1 - m_ph[i];
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end else begin
                m_cnt[i] = 0;
                m_ph[i]  = 0;
            end
            if (key) any_key = 1'b1;
            if (m_gain[i] != 0) all_zero = 1'b0;
        end
        m_idle = all_zero && !any_key;
    endtask

    // Monitor: one line per accepted write, compared against the scoreboard head.
    always @(negedge clk) begin
        if (snd.write_audio_out) begin
            if (reset) begin
                check_eq("write_in_reset", 32'(snd.write_audio_out), 32'd0);
            end else if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 32'(snd.write_audio_out), 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                $display("write %0d sample=0x%08h expected=0x%08h", wr_count, snd.sample_out, e);
                check_eq("sample", snd.sample_out, e);
                last_sample = snd.sample_out;
                wr_count++;
            end
        end
    end

    // Drive one write's worth of note inputs, predict its sample, wait for the strobe.
    // The optional stall holds audio_out_allowed low for that many cycles in WRITE.
    task automatic step(input logic [3:0] en, input logic [31:0] hp, input int stall,
                        output int waited);
        int start;
        snd.note_en          = en;
        snd.note_half_period = hp;
        exp_q.push_back(model_sample());
        model_update(en, hp);
        start  = wr_count;
        waited = 0;
        if (stall > 0) begin
            logic [31:0] held;
            snd.audio_out_allowed = 1'b0;
            @(negedge clk); #1;
            held = snd.sample_out;
            for (int k = 0; k < stall; k++) begin
                @(negedge clk); #1;
                check_eq("bp_no_strobe", 32'(snd.write_audio_out), 32'd0);
                check_eq("bp_sample_hold", snd.sample_out, held);
            end
            @(posedge clk); #1;
            snd.audio_out_allowed = 1'b1;
        end
        while (wr_count == start && waited < 40) begin
            @(negedge clk); #1;
            waited++;
        end
        check_eq("write_seen", 32'(wr_count - start), 32'd1);
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        snd.note_en = '0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          waited;
        int          rel_writes;
        int          s_now;
        int          mag;
        int          prev_mag;
        int          guard;
        bit          pos;
        logic [31:0] hp_bus;

        model_reset();
        reset                 = 1'b1;
        snd.note_en           = 4'hF;
        snd.note_half_period  = 32'h02020202;
        snd.audio_out_allowed = 1'b1;

        // Reset held with everything keyed: nothing may escape.
        repeat (3) begin
            @(negedge clk); #1;
            check_eq("rst_write",  32'(snd.write_audio_out), 32'd0);
            check_eq("rst_sample", snd.sample_out, 32'd0);
            check_eq("rst_active", 32'(snd.active), 32'd0);
        end
        snd.note_en = 4'h0;
        reset       = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
            check_eq("idle_active", 32'(snd.active), 32'd0);
            check_eq("idle_write",  32'(snd.write_audio_out), 32'd0);
        end

        // Single voice, hp0 = 2.
        hp_bus = 32'h00000002;
        step(4'b0001, hp_bus, 0, waited);
        check_eq("first_latency", 32'(waited), 32'd2);
        check_eq("first_sample", last_sample, 32'h00000000);
        step(4'b0001, hp_bus, 0, waited);
        check_eq("rate_2cyc_a", 32'(waited), 32'd1);
        check_eq("second_sample", last_sample, 32'h001FFFC0);
        step(4'b0001, hp_bus, 0, waited);
        check_eq("rate_2cyc_b", 32'(waited), 32'd1);
        check_eq("third_sample", last_sample, 32'hFFC00080);

        // Back-pressure for 10 cycles; the sequence must resume unchanged.
        step(4'b0001, hp_bus, 10, waited);

        // Sustain to 300 keyed writes so the envelope saturates.
        for (int k = 0; k < 296; k++) step(4'b0001, hp_bus, 0, waited);

        // Release: linear decay by one gain step per write, then IDLE.
        rel_writes = 0;
        prev_mag   = 0;
        while (!m_idle && rel_writes < 400) begin
            step(4'b0000, hp_bus, 0, waited);
            rel_writes++;
            s_now = $signed(last_sample);
            mag   = (s_now < 0) ? -s_now : s_now;
            if (rel_writes == 1) check_eq("rel_first_mag", 32'(mag), 32'(32767 * 255 * 64));
            else                 check_eq("rel_step", 32'(prev_mag - mag), 32'(32767 * 64));
            prev_mag = mag;
        end
        check_eq("release_writes", 32'(rel_writes), 32'd255);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (20) begin
            @(negedge clk); #1;
            check_eq("post_rel_active", 32'(snd.active), 32'd0);
            check_eq("post_rel_write",  32'(snd.write_audio_out), 32'd0);
        end

        // Four-voice chord at full gain: peak and sign flip, no overflow.
        do_reset();
        hp_bus = 32'h01010101;
        for (int k = 0; k < 260; k++) step(4'hF, hp_bus, 0, waited);
        for (int k = 0; k < 2; k++) begin
            pos = (m_ph[0] == 0);
            step(4'hF, hp_bus, 0, waited);
            check_eq("chord_peak", last_sample, pos ? 32'h7F7F0100 : 32'h8080FF00);
        end

        // Live half-period shrink 10 -> 2 with cnt0 = 7 must wrap immediately.
        do_reset();
        hp_bus = 32'h0000000A;
        guard  = 0;
        while (m_cnt[0] != 7 && guard < 20) begin
            step(4'b0001, hp_bus, 0, waited);
            guard++;
        end
        hp_bus = 32'h00000002;
        step(4'b0001, hp_bus, 0, waited);
        step(4'b0001, hp_bus, 0, waited);
        check_eq("hp_shrink_sign", 32'(last_sample[31]), 32'd1);

        // Reset while parked in WRITE.
        snd.audio_out_allowed = 1'b0;
        @(negedge clk); #1;
        check_eq("pre_rst_active", 32'(snd.active), 32'd1);
        reset                 = 1'b1;
        snd.audio_out_allowed = 1'b1;
        #1;
        check_eq("rst_cycle_write", 32'(snd.write_audio_out), 32'd0);
        @(negedge clk); #1;
        check_eq("midrst_write",  32'(snd.write_audio_out), 32'd0);
        check_eq("midrst_sample", snd.sample_out, 32'd0);
        check_eq("midrst_active", 32'(snd.active), 32'd0);
        snd.note_en = 4'h0;
        reset       = 1'b0;
        model_reset();
        exp_q.delete();
        repeat (3) begin
            @(negedge clk); #1;
            check_eq("final_idle", 32'(snd.active), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/tone_synth.md
# tone_synth

Parameterised polyphonic square-wave tone generator with per-voice linear attack/release envelopes. It drives the Audio_Controller DAC FIFO write port directly. It replaces the single-tone, switch-selected generator: any subset of NUM_NOTES voices may sound at once, each with a programmable half-period, with click-free note on/off. It sits between the note-select logic (switches/game FSM) and Audio_Controller, and feeds the same sample to left and right channels.

## Interface
- NUM_NOTES, 4: number of voices (≥1).
- HP_W, 8: width of each half-period, in samples.
- AMP_W, 16: voice amplitude width; a voice's value is ±(2^(AMP_W-1)-1).
- ENV_W, 8: per-voice gain width; gain ranges 0..GMAX, where GMAX = 2^ENV_W-1.
- ENV_STEP, 1: gain change per written sample (1..GMAX).
- OUT_W, 32: sample width. Must satisfy OUT_W ≥ SUM_W, where SUM_W = AMP_W+ENV_W+clog2(NUM_NOTES).

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- note_en  in  NUM_NOTES  voice i is keyed on while bit i = 1.
- note_half_period  in  NUM_NOTES*HP_W  voice i half-period at bits [i*HP_W +: HP_W]. A value of 0 means voice i is silent and treated as not keyed.
- audio_out_allowed  in  1  DAC FIFO has room (from Audio_Controller).
- write_audio_out  out  1  one-cycle write strobe to Audio_Controller.
- sample_out  out  OUT_W  signed sample; wire to both left and right channel inputs.
- active  out  1  1 when the FSM is not in IDLE.

## Operation
- Per-voice state: cnt_i (HP_W bits), ph_i (1 bit), gain_i (ENV_W bits).
- key_i = note_en[i] & (hp_i != 0).
- FSM states and transitions:
  - IDLE → MIX when any key_i = 1.
  - MIX → WRITE unconditionally, after 1 cycle.
  - WRITE holds while audio_out_allowed = 0.
  - WRITE leaves on an accepted write. It goes to IDLE if, after the update, all gain_i = 0 and no key_i = 1. Otherwise it goes to MIX.
- MIX: load sample_out from the current voice state.
  - v_i = ph_i ? -(2^(AMP_W-1)-1) : +(2^(AMP_W-1)-1).
  - p_i = v_i * gain_i; signed, AMP_W+ENV_W bits, cannot overflow.
  - sum = Σ p_i; signed, SUM_W bits.
  - sample_out = sum << (OUT_W-SUM_W), with zero fill in the low bits.
- write_audio_out = (state == WRITE) & audio_out_allowed. This path is combinational from the state register.
- Accepted write: the cycle where write_audio_out = 1. At that edge every voice updates, using key_i sampled in that cycle:
  - Gain: if key_i, gain_i = min(GMAX, gain_i+ENV_STEP). Otherwise gain_i = max(0, gain_i-ENV_STEP). Use saturating arithmetic with no wrap.
  - Oscillator runs if key_i or gain_i (old value) ≠ 0. When running: if cnt_i ≥ hp_i-1, then cnt_i = 0 and ph_i toggles; otherwise cnt_i++. The ≥ comparison makes a live half-period decrease safe.
  - Oscillator not running: cnt_i = 0, ph_i = 0.
  - Released voices keep oscillating at their last hp_i until their gain reaches 0. If hp_i = 0 during release, hold cnt_i and ph_i.
- Note on/off and half-period changes take effect only at accepted writes. Voices never change between writes.

## Timing
- Reset values: state IDLE; sample_out 0; write_audio_out 0; active 0; all cnt, ph and gain 0.
- Latency from key-on to first write: 1 cycle in IDLE→MIX, 1 cycle in MIX, then WRITE (immediate if audio_out_allowed = 1).
- Maximum write rate is one per 2 cycles.
- The first sample after key-on from silence is 0 (gain 0). Gain reaches GMAX after ceil(GMAX/ENV_STEP) writes.
- Back-pressure: while in WRITE with audio_out_allowed = 0, sample_out and all voice state are frozen.
- A key change and an accepted write in the same cycle: the key value sampled in that cycle is used.
- Reset mid-operation (any state): the next cycle shows reset values, and nothing is written in the reset cycle.
- Full period of a voice = 2·hp_i accepted samples.

## Test plan
- Reset: hold reset with note_en = 4'hF and audio_out_allowed = 1 → write_audio_out = 0, sample_out = 0, active = 0. Release reset with note_en = 0 → stays IDLE.
- Single voice, defaults: note_en = 0001, hp0 = 2, audio_out_allowed = 1 → written samples are 0x00000000, 0x001FFFC0, 0xFFC00080, with a write strobe every 2 cycles.
- Back-pressure: drop audio_out_allowed for 10 cycles in WRITE → no strobe, sample_out constant, voice state frozen. On re-assert, the next sample continues the sequence unchanged.
- Release: key voice 0 for 300 writes (gain = 255), then clear note_en → exactly 255 further writes with magnitude decreasing by 32767·64 per step. Then IDLE, active = 0, no more strobes.
- Chord: all 4 voices, hp = 1, run to gain 255 and sample while all ph = 0 → 0x7F7F0100. Check that no overflow occurs and that the sign flips correctly when all ph = 1.
- Mid-note reset and live hp change: reduce hp0 from 10 to 2 while cnt0 = 7 → wraps at the next write. Assert reset in WRITE → all outputs are 0 next cycle.
